// File: rtl/turn_input_cond.sv
// Turn-lever input conditioning: synchronise, debounce, edge-detect and
// tick-align lever/hazard requests for the tail-light sequencer.
module turn_input_cond #(
    parameter int DB_LEN   = 1000000,
    parameter int TICK_LEN = 16777216
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_l,
    input  logic sw_r,
    input  logic sw_halt,
    output logic db_l,
    output logic db_r,
    output logic db_halt,
    output logic rise_l,
    output logic rise_r,
    output logic rise_halt,
    output logic tick,
    output logic l_out,
    output logic r_out,
    output logic halt_out
);

    localparam int DBW = (DB_LEN > 2) ? $clog2(DB_LEN) : 1;
    localparam int TKW = (TICK_LEN > 2) ? $clog2(TICK_LEN) : 1;
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_LEN - 1);
    localparam logic [TKW-1:0] TK_MAX = TKW'(TICK_LEN - 1);

    // channel order everywhere: [0]=left, [1]=right, [2]=halt
    logic [2:0]     w_sw;
    logic [2:0]     r_sync1;
    logic [2:0]     r_sync2;
    logic [2:0]     r_db;
    logic [2:0]     r_rise;
    logic [2:0]     r_pend;
    logic [DBW-1:0] r_cnt [3];
    logic [TKW-1:0] r_tick_cnt;
    logic           w_tick;
    logic [2:0]     w_req;
    logic           w_halt_nxt;
    logic           r_l_out;
    logic           r_r_out;
    logic           r_halt_out;

    assign w_sw = {sw_halt, sw_r, sw_l};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_sw;
            r_sync2 <= r_sync1;
        end
    end

    // a change is accepted only after DB_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db   <= '0;
            r_rise <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_rise[i] <= 1'b0;
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_MAX) begin
                    r_db[i]   <= r_sync2[i];
                    r_rise[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TK_MAX) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == TK_MAX);

    // a rise landing on the tick edge is consumed there, never latched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else if (w_tick) begin
            r_pend <= '0;
        end else begin
            r_pend <= r_pend | r_rise;
        end
    end

    assign w_req      = r_db | r_pend | r_rise;
    assign w_halt_nxt = w_req[2] | (w_req[0] & w_req[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_l_out    <= 1'b0;
            r_r_out    <= 1'b0;
            r_halt_out <= 1'b0;
        end else if (w_tick) begin
            r_halt_out <= w_halt_nxt;
            r_l_out    <= w_req[0] & ~w_halt_nxt;
            r_r_out    <= w_req[1] & ~w_halt_nxt;
        end
    end

    assign db_l      = r_db[0];
    assign db_r      = r_db[1];
    assign db_halt   = r_db[2];
    assign rise_l    = r_rise[0];
    assign rise_r    = r_rise[1];
    assign rise_halt = r_rise[2];
    assign tick      = w_tick;
    assign l_out     = r_l_out;
    assign r_out     = r_r_out;
    assign halt_out  = r_halt_out;

endmodule

// File: doc/turn_input_cond.md
TURN_INPUT_COND -- requirements
Module: turn_input_cond

Interface
REQ-001 SHALL have parameter DB_LEN, default 1000000: consecutive stable cycles required to accept a switch change (>=2).
REQ-002 SHALL have parameter TICK_LEN, default 16777216: period in clk cycles of the command-update tick (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all flops update on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports sw_l, sw_r, sw_halt  input  1 each  raw asynchronous lever/hazard switches, active-high.
REQ-006 SHALL have ports db_l, db_r, db_halt  output  1 each  debounced switch levels.
REQ-007 SHALL have ports rise_l, rise_r, rise_halt  output  1 each  one-cycle pulse on debounced 0->1.
REQ-008 SHALL have port tick  output  1  one-cycle pulse every TICK_LEN cycles; step enable for the downstream tail-light FSM.
REQ-009 SHALL have ports l_out, r_out, halt_out  output  1 each  tick-aligned, conflict-resolved commands for the tail-light FSM.

Function
REQ-010 Each sw_* SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Per channel, a debounce counter SHALL clear whenever synced value == db_*, otherwise increment.
REQ-012 When the counter == DB_LEN-1 and the synced value still differs, db_* SHALL take the synced value and the counter SHALL clear on that edge.
REQ-013 A raw change held stable SHALL therefore reach db_* exactly 2+DB_LEN edges after first sampling; any reversion earlier SHALL leave db_* unchanged.
REQ-014 rise_* SHALL be high for exactly the first cycle in which db_* is 1 after being 0; falling transitions produce no pulse.
REQ-015 tick_cnt SHALL count 0..TICK_LEN-1 and wrap to 0; tick = (tick_cnt == TICK_LEN-1); first tick TICK_LEN-1 edges after reset release.
REQ-016 Pending flags pend_l/pend_r/pend_halt SHALL set on rise_* and clear on any edge where tick is high.
REQ-017 rise_* coincident with tick SHALL be consumed by that tick; the pend flag SHALL NOT set.
REQ-018 Effective request per channel: req_x = db_x | pend_x | rise_x.
REQ-019 On an edge with tick high: halt_out <= req_halt | (req_l & req_r); l_out <= req_l & ~(that halt value); r_out <= req_r & ~(that halt value).
REQ-020 l_out, r_out, halt_out SHALL hold between ticks; at most one of them SHALL ever be high.
REQ-021 Short lever pulses (accepted by debounce, released before the next tick) SHALL still produce one tick period of the command.

Reset
REQ-022 With rst high at an edge: synchronizers, debounce counters, db_*, rise_*, pend_*, tick_cnt, l_out, r_out, halt_out SHALL all be 0 after that edge; tick SHALL be 0.
REQ-023 Reset mid-debounce or mid-tick-period SHALL discard progress; switches held high through reset SHALL reappear 2+DB_LEN edges after release.
REQ-024 No output SHALL depend on any state other than the registers named above (no uninitialised flops).

Verification (DB_LEN=4, TICK_LEN=8)
REQ-025 rst released, sw_l 0->1 held -> db_l=1 and rise_l=1 after edge 6 from first sample, rise_l=0 next cycle; db_r, db_halt stay 0.
REQ-026 sw_r high 3 cycles then low, repeated 5 times -> db_r, rise_r, r_out never assert.
REQ-027 sw_l and sw_r both held until debounced -> at next tick halt_out=1, l_out=0, r_out=0; held while both stay high.
REQ-028 sw_l high 7 cycles placed just after a tick -> db_l pulses, pend_l set; at next tick l_out=1 for 8 cycles, then 0 at following tick.
REQ-029 rise_halt arranged on same cycle as tick -> halt_out=1 from that edge; pend_halt remains 0.
REQ-030 rst pulsed 1 cycle while sw_l held high and l_out=1 -> all outputs 0 next cycle; first tick 7 edges after release; db_l returns 6 edges after release.
